// File: rtl/flex_counter_pkg.sv
// Shared definitions for the multi-channel flexible counter.
// Holds direction encodings and the single-step transition function.
package flex_counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Widest channel supported; narrower counts are zero-extended into it.
    localparam int MAX_W = 32;

    // Returns {wrap, next} for one step of a counter with rollover value rv.
    function automatic logic [MAX_W:0] next_count(
        input logic [MAX_W-1:0] c,
        input logic [MAX_W-1:0] rv,
        input logic             down
    );
        logic [MAX_W:0] r;
        if (rv == '0) begin
            r = {1'b1, {MAX_W{1'b0}}};
        end else if (down == DIR_UP) begin
            if (c >= rv) r = {1'b1, MAX_W'(1)};
            else         r = {1'b0, c + MAX_W'(1)};
        end else begin
            if (c <= MAX_W'(1) || c > rv) r = {1'b1, rv};
            else                          r = {1'b0, c - MAX_W'(1)};
        end
        return r;
    endfunction

endpackage

// File: rtl/flex_counter_array_chan.sv
// One counter channel: clear/load/step/hold with rollover flag and wrap pulse.
// Exports the combinational wrap of a step taken this cycle for cascading.
module flex_counter_chan
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    eff_en,
    input  logic                    count_down,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse,
    output logic                    wrap_now
);

    logic [MAX_W:0]          nc;
    logic [NUM_CNT_BITS-1:0] step_next;
    logic                    step_wrap;
    logic                    unused_nc;

    assign nc        = next_count(MAX_W'(count_out), MAX_W'(rollover_val),
                                  count_down);
    assign step_next = nc[NUM_CNT_BITS-1:0];
    assign step_wrap = nc[MAX_W];
    assign unused_nc = ^nc;

    // Only a step that actually wins priority may carry into the next channel.
    assign wrap_now = eff_en & ~clear & ~load & step_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else if (clear) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else if (load) begin
            count_out     <= load_val;
            rollover_flag <= (load_val == rollover_val);
            wrap_pulse    <= 1'b0;
        end else if (eff_en) begin
            count_out     <= step_next;
            rollover_flag <= (step_next == rollover_val);
            wrap_pulse    <= step_wrap;
        end else begin
            rollover_flag <= (count_out == rollover_val);
            wrap_pulse    <= 1'b0;
        end
    end

endmodule

// File: rtl/flex_counter_array.sv
// NUM_CH independent flexible counters with optional cascading
// into one wide counter, channel 0 being the least significant.
module flex_counter_array
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2,
    parameter bit CASCADE      = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              clear,
    input  logic [NUM_CH-1:0]              count_enable,
    input  logic [NUM_CH-1:0]              count_down,
    input  logic [NUM_CH-1:0]              load,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]              rollover_flag,
    output logic [NUM_CH-1:0]              wrap_pulse
);

    logic [NUM_CH-1:0] eff_en;
    logic [NUM_CH-1:0] wrap_now;
    logic              unused_wrap;

    assign eff_en[0]   = count_enable[0];
    assign unused_wrap = wrap_now[NUM_CH-1];

    for (genvar i = 1; i < NUM_CH; i++) begin : g_gate
        if (CASCADE) begin : g_casc
            assign eff_en[i] = count_enable[i] & wrap_now[i-1];
        end else begin : g_free
            assign eff_en[i] = count_enable[i];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flex_counter_chan #(
            .NUM_CNT_BITS(NUM_CNT_BITS)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .clear        (clear[i]),
            .load         (load[i]),
            .eff_en       (eff_en[i]),
            .count_down   (count_down[i]),
            .load_val     (load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_val (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .count_out    (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_flag(rollover_flag[i]),
            .wrap_pulse   (wrap_pulse[i]),
            .wrap_now     (wrap_now[i])
        );
    end

endmodule

// File: tb/tb_flex_counter_array.sv
// Scoreboard bench: a free-running array and a cascaded array share stimulus;
// each vector names which one is checked and its expected outputs.
module tb_flex_counter_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] clear, en, dn, ld;
    logic [7:0] lv, rv;

    logic [7:0] cnt_a, cnt_c;
    logic [1:0] flg_a, flg_c, wrp_a, wrp_c;

    typedef struct {
        bit         sel;
        logic [7:0] c;
        logic [1:0] f;
        logic [1:0] w;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    bit   done   = 1'b0;

    always #5 clk = ~clk;

    flex_counter_array #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .count_enable(en),
        .count_down(dn), .load(ld), .load_val(lv), .rollover_val(rv),
        .count_out(cnt_a), .rollover_flag(flg_a), .wrap_pulse(wrp_a)
    );

    flex_counter_array #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .count_enable(en),
        .count_down(dn), .load(ld), .load_val(lv), .rollover_val(rv),
        .count_out(cnt_c), .rollover_flag(flg_c), .wrap_pulse(wrp_c)
    );

    task automatic drv(
        input bit r, input logic [1:0] cl, e, d, l,
        input logic [7:0] lval, rval,
        input bit s, input logic [7:0] ec, input logic [1:0] ef, ew
    );
        exp_t x;
        rst = r; clear = cl; en = e; dn = d; ld = l; lv = lval; rv = rval;
        x.sel = s; x.c = ec; x.f = ef; x.w = ew; x.id = vec_id;
        sb.push_back(x);
        vec_id++;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got %h want %h", nm, id, act, req);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (x.sel) begin
                    chk("casc_count", x.id, cnt_c, x.c);
                    chk("casc_flag", x.id, {6'd0, flg_c}, {6'd0, x.f});
                    chk("casc_wrap", x.id, {6'd0, wrp_c}, {6'd0, x.w});
                end else begin
                    chk("count", x.id, cnt_a, x.c);
                    chk("flag", x.id, {6'd0, flg_a}, {6'd0, x.f});
                    chk("wrap", x.id, {6'd0, wrp_a}, {6'd0, x.w});
                end
            end
        end
    end

    initial begin : stim
        // reset (ch1 of the free array is held cleared during phase A)
        drv(1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00);
        // up count rv=5
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h05, 0, 8'h01, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h05, 0, 8'h02, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h05, 0, 8'h03, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h05, 0, 8'h04, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h05, 0, 8'h05, 2'b01, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h05, 0, 8'h01, 2'b00, 2'b01);
        // down count rv=3 from clear
        drv(0, 2'b11, 2'b00, 2'b01, 2'b00, 8'h00, 8'h03, 0, 8'h00, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b01, 2'b00, 8'h00, 8'h03, 0, 8'h03, 2'b01, 2'b01);
        drv(0, 2'b10, 2'b01, 2'b01, 2'b00, 8'h00, 8'h03, 0, 8'h02, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b01, 2'b00, 8'h00, 8'h03, 0, 8'h01, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b01, 2'b00, 8'h00, 8'h03, 0, 8'h03, 2'b01, 2'b01);
        // out-of-range load, wrap to 1, stall at rv
        drv(0, 2'b10, 2'b00, 2'b00, 2'b01, 8'h07, 8'h04, 0, 8'h07, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h04, 0, 8'h01, 2'b00, 2'b01);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h04, 0, 8'h02, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h04, 0, 8'h03, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h04, 0, 8'h04, 2'b01, 2'b00);
        drv(0, 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 8'h04, 0, 8'h04, 2'b01, 2'b00);
        drv(0, 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 8'h04, 0, 8'h04, 2'b01, 2'b00);
        // direction change mid-count
        drv(0, 2'b10, 2'b01, 2'b01, 2'b00, 8'h00, 8'h04, 0, 8'h03, 2'b00, 2'b00);
        // priority: clear > load > step, then rst > load
        drv(0, 2'b11, 2'b01, 2'b00, 2'b01, 8'h09, 8'h09, 0, 8'h00, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b01, 8'h09, 8'h09, 0, 8'h09, 2'b01, 2'b00);
        drv(1, 2'b00, 2'b01, 2'b00, 2'b01, 8'h09, 8'h09, 0, 8'h00, 2'b00, 2'b00);
        // rv=0 under enable, both directions
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b01);
        drv(0, 2'b10, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b01);
        drv(0, 2'b10, 2'b01, 2'b01, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b01);
        // clear with rv=0 drops the flag until the following hold
        drv(0, 2'b11, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00);
        drv(0, 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00);
        // cascade rv0=3 rv1=2
        drv(0, 2'b11, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h00, 2'b00, 2'b00);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h01, 2'b00, 2'b00);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h02, 2'b00, 2'b00);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h03, 2'b01, 2'b00);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h11, 2'b00, 2'b01);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h12, 2'b00, 2'b00);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h13, 2'b01, 2'b00);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h21, 2'b10, 2'b01);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h22, 2'b10, 2'b00);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h23, 2'b11, 2'b00);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h11, 2'b00, 2'b11);
        // ch1 enabled alone never steps when cascaded
        drv(0, 2'b00, 2'b10, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h11, 2'b00, 2'b00);
        drv(0, 2'b00, 2'b10, 2'b00, 2'b00, 8'h00, 8'h23, 1, 8'h11, 2'b00, 2'b00);
        // a load on ch0 that would otherwise wrap blocks the carry
        drv(0, 2'b00, 2'b11, 2'b00, 2'b01, 8'h03, 8'h23, 1, 8'h13, 2'b01, 2'b00);
        drv(0, 2'b00, 2'b11, 2'b00, 2'b01, 8'h03, 8'h23, 1, 8'h13, 2'b01, 2'b00);
        done = 1'b1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while ((!done || sb.size() > 0) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (sb.size() != 0 || !done) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
